mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Load/store unit that initiates data-memory transactions on behalf of the CPU execute stage. It accepts one load or store per request handshake and issues word-aligned accesses with byte strobes to the data memory. Misaligned accesses that cross a word boundary are split into two memory accesses. The block returns sign- or zero-extended load data, plus an error flag for illegal codes or a memory timeout.

Parameters:
MAX_WAIT, 255, cycles without mem_ack before an access is aborted with an error (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  unit idle; request accepted when req_valid & req_ready
req_load  in  1  1 = load, 0 = store
req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse (loads and stores)
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid; illegal funct3 or timeout
mem_req  out  1  memory access request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address, bits [1:0] = 0
mem_wstrb  out  4  byte-lane write enables; 0 when mem_we = 0
mem_wdata  out  32  write data by lane
mem_ack  in  1  access complete; mem_rdata valid in the same cycle
mem_rdata  in  32  read data by lane

Behaviour:
- FSM states: IDLE, ACC0, ACC1, RESP. Outputs are registered except req_ready, which equals (state == IDLE).
- Reset values: state IDLE; mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err all 0; wait counter 0.
- Reset mid-operation abandons the in-flight access. No resp_valid is produced, and mem_req is 0 in the cycle after rst.
- Accept (cycle 0): latch the operation. Let off = addr[1:0] and nbytes = 1, 2 or 4.
  - Illegal funct3: go to RESP with err = 1 and no memory access. Illegal means load 011/110/111, or store with funct3[2] = 1 or 011.
  - Otherwise go to ACC0.
- Split rule: split = (off + nbytes > 4). This covers LW/SW with off ≠ 0 and LH/LHU/SH with off = 3.
- ACC0 (from cycle 1):
  - mem_req = 1, mem_addr = {addr[31:2], 00}.
  - mem_wdata = req_wdata rotated left by 8*off.
  - mem_wstrb = lanes off .. min(off + nbytes, 4) − 1.
  - Outputs are stable until mem_ack.
- ACC1: mem_addr = first address + 4, mem_wstrb = lanes 0 .. (off + nbytes − 5), same rotated wdata.
- mem_ack in ACCx captures mem_rdata into byte buffer lanes 0–3 (ACC0) or 4–7 (ACC1).
  - From ACC0: go to ACC1 if split, otherwise RESP.
  - From ACC1: go to RESP.
  - There is no idle cycle between ACC0 and ACC1; mem_req stays high.
- mem_ack while mem_req = 0 is ignored.
- Load result: bytes off .. off + nbytes − 1 of the buffer. LB/LH sign-extend; LBU/LHU/LW zero-extend (LW needs no extension).
- Timeout: the wait counter counts cycles in ACCx without ack and clears on each new access. When it reaches MAX_WAIT, the unit aborts: mem_req → 0 and state goes to RESP with err = 1 and rdata = 0. This applies to the second access of a split too, and a partial store is not rolled back.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Latency with immediate ack:
  - Aligned: accept at cycle 0, mem_req at cycle 1, resp_valid at cycle 2, req_ready at cycle 3.
  - Split: resp_valid at cycle 3.

Decomposition:
- lsu_pkg:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW;
  - FSM state encoding;
  - nbytes function;
  - illegal-code predicate.
- Sub-module lsu_align: combinational. Maps the 8-byte buffer plus off/funct3 to the extended 32-bit result, and wdata/off/nbytes to rotated wdata and strobes for both accesses.

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF, ack on first mem_req cycle -> mem_addr 0x10, mem_wstrb 1111, mem_wdata 0xDEADBEEF, mem_we 1; resp_valid cycle 2, err 0, rdata 0.
2. LB addr 0x13, mem_rdata 0x80123456 -> resp_rdata 0xFFFFFF80. Repeat as LBU -> 0x00000080, and as LH addr 0x12 -> 0xFFFF8012.
3. LW addr 0x22: first mem_addr 0x20 (rdata 0x44332211), then 0x24 (rdata 0x88776655) -> resp_rdata 0x66554433, resp_valid cycle 3 with immediate acks.
4. SH addr 0x07, wdata 0x0000ABCD -> access 0x04, wstrb 1000, wdata 0xCD0000AB; then access 0x08, wstrb 0001, same wdata; err 0.
5. MAX_WAIT = 4, LW addr 0x40, no ack -> mem_req high 4 cycles then 0; resp_valid with err 1, rdata 0; late mem_ack afterwards has no effect.
6. Load funct3 011 -> no mem_req, resp_valid cycle 1 with err 1. Separately, rst asserted during ACC1 of a split LW -> no resp_valid, mem_req 0 next cycle, req_ready 1 after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM encoding
// and the small decode helpers used by the top and the alignment logic.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes from the low two funct3 bits (byte, half, word).
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic illegal_op(input logic load, input logic [2:0] f3);
        if (load)
            illegal_op = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        else
            illegal_op = f3[2] || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store data rotation and strobes
// for both halves of a split access, and load byte extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [1:0]  wr_off,
    input  logic [2:0]  wr_nbytes,
    output logic [31:0] wdata_rot,
    output logic [3:0]  wstrb0,
    output logic [3:0]  wstrb1,
    // Buffer bytes 0..6; byte 7 can never belong to a result (off 3 + 4 bytes ends at 6).
    input  logic [55:0] rd_buf,
    input  logic [1:0]  rd_off,
    input  logic [2:0]  rd_funct3,
    output logic [31:0] rdata
);

    logic [3:0]  mask;
    logic [7:0]  lanes;
    logic [31:0] rd_word;

    always_comb begin
        case (wr_nbytes)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        lanes  = {4'b0000, mask} << wr_off;
        wstrb0 = lanes[3:0];
        wstrb1 = lanes[7:4];

        case (wr_off)
            2'd0:    wdata_rot = wdata;
            2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
            2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
            default: wdata_rot = {wdata[7:0],  wdata[31:8]};
        endcase
    end

    always_comb begin
        case (rd_off)
            2'd0:    rd_word = rd_buf[31:0];
            2'd1:    rd_word = rd_buf[39:8];
            2'd2:    rd_word = rd_buf[47:16];
            default: rd_word = rd_buf[55:24];
        endcase

        case (rd_funct3)
            F3_LB:   rdata = {{24{rd_word[7]}}, rd_word[7:0]};
            F3_LH:   rdata = {{16{rd_word[15]}}, rd_word[15:0]};
            F3_LBU:  rdata = {24'h0, rd_word[7:0]};
            F3_LHU:  rdata = {16'h0, rd_word[15:0]};
            default: rdata = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one CPU request at a time, word-aligned memory accesses,
// boundary-crossing accesses split in two, per-access timeout.
//
// state   | meaning
// IDLE    | ready for a request
// ACC0    | first (or only) memory access outstanding
// ACC1    | second half of a split access outstanding
// RESP    | one-cycle response pulse
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(MAX_WAIT - 1);

    lsu_state_t state, state_nxt;

    logic          mem_req_nxt, mem_we_nxt;
    logic [31:0]   mem_addr_nxt, mem_wdata_nxt;
    logic [3:0]    mem_wstrb_nxt;
    logic          resp_valid_nxt, resp_err_nxt;
    logic [31:0]   resp_rdata_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;

    logic          op_load, op_split;
    logic [2:0]    op_funct3;
    logic [1:0]    op_off;
    logic [3:0]    op_wstrb1;
    logic [31:0]   buf_lo;

    logic [31:0]   wdata_rot, ld_data;
    logic [3:0]    wstrb0, wstrb1;
    logic [55:0]   rd_buf;
    logic          accept;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && (state == ST_IDLE);

    // On the final ack the current mem_rdata supplies the newest lanes directly.
    assign rd_buf = (state == ST_ACC1) ? {mem_rdata[23:0], buf_lo} : {24'h0, mem_rdata};

    lsu_align u_align (
        .wdata     (req_wdata),
        .wr_off    (req_addr[1:0]),
        .wr_nbytes (nbytes(req_funct3[1:0])),
        .wdata_rot (wdata_rot),
        .wstrb0    (wstrb0),
        .wstrb1    (wstrb1),
        .rd_buf    (rd_buf),
        .rd_off    (op_off),
        .rd_funct3 (op_funct3),
        .rdata     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_load   <= 1'b0;
            op_split  <= 1'b0;
            op_funct3 <= 3'b000;
            op_off    <= 2'b00;
            op_wstrb1 <= 4'h0;
            buf_lo    <= 32'h0;
        end else begin
            if (accept) begin
                op_load   <= req_load;
                op_split  <= |wstrb1;
                op_funct3 <= req_funct3;
                op_off    <= req_addr[1:0];
                op_wstrb1 <= wstrb1;
            end
            if (state == ST_ACC0 && mem_ack)
                buf_lo <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wstrb  <= 4'h0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wstrb  <= mem_wstrb_nxt;
            mem_wdata  <= mem_wdata_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wstrb_nxt  = mem_wstrb;
        mem_wdata_nxt  = mem_wdata;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = 32'h0;
        resp_err_nxt   = 1'b0;
        wait_cnt_nxt   = wait_cnt;

        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (illegal_op(req_load, req_funct3)) begin
                        state_nxt      = ST_RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = ST_ACC0;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = !req_load;
                        mem_addr_nxt  = {req_addr[31:2], 2'b00};
                        mem_wstrb_nxt = req_load ? 4'h0 : wstrb0;
                        mem_wdata_nxt = req_load ? 32'h0 : wdata_rot;
                        wait_cnt_nxt  = WAIT_LOAD;
                    end
                end
            end
            ST_ACC0, ST_ACC1: begin
                if (mem_ack && state == ST_ACC0 && op_split) begin
                    state_nxt     = ST_ACC1;
                    mem_addr_nxt  = mem_addr + 32'd4;
                    mem_wstrb_nxt = op_load ? 4'h0 : op_wstrb1;
                    wait_cnt_nxt  = WAIT_LOAD;
                end else if (mem_ack || wait_cnt == '0) begin
                    state_nxt      = ST_RESP;
                    mem_req_nxt    = 1'b0;
                    mem_we_nxt     = 1'b0;
                    mem_addr_nxt   = 32'h0;
                    mem_wstrb_nxt  = 4'h0;
                    mem_wdata_nxt  = 32'h0;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = !mem_ack;
                    resp_rdata_nxt = (mem_ack && op_load) ? ld_data : 32'h0;
                end else begin
                    wait_cnt_nxt = wait_cnt - CW'(1);
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: aligned/split loads and stores, extension,
// illegal codes, timeout and mid-access reset.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic load, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        chk("req_ready_at_issue", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_load   = load;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
    endtask

    // Check the outstanding access, ack it immediately, advance one cycle.
    task automatic ack_access(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic we, input logic [31:0] rdata);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(strb));
        if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic expect_resp(input string tag, input logic err, input logic [31:0] rdata);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'(err));
        chk({tag, "_resp_rdata"}, resp_rdata, rdata);
        chk({tag, "_mem_req_in_resp"}, 32'(mem_req), 32'd0);
        step();
        chk({tag, "_resp_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        step();

        // Aligned SW
        issue(1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
        ack_access("sw", 32'h10, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0);
        expect_resp("sw", 1'b0, 32'h0);

        // Byte/half loads with sign and zero extension
        issue(1'b1, 3'b000, 32'h13, 32'h0);
        ack_access("lb", 32'h10, 4'b0000, 32'h0, 1'b0, 32'h80123456);
        expect_resp("lb", 1'b0, 32'hFFFFFF80);
        issue(1'b1, 3'b100, 32'h13, 32'h0);
        ack_access("lbu", 32'h10, 4'b0000, 32'h0, 1'b0, 32'h80123456);
        expect_resp("lbu", 1'b0, 32'h00000080);
        issue(1'b1, 3'b001, 32'h12, 32'h0);
        ack_access("lh", 32'h10, 4'b0000, 32'h0, 1'b0, 32'h80123456);
        expect_resp("lh", 1'b0, 32'hFFFF8012);

        // Split LW: back-to-back accesses, response in cycle 3
        issue(1'b1, 3'b010, 32'h22, 32'h0);
        ack_access("lw_a", 32'h20, 4'b0000, 32'h0, 1'b0, 32'h44332211);
        ack_access("lw_b", 32'h24, 4'b0000, 32'h0, 1'b0, 32'h88776655);
        expect_resp("lw", 1'b0, 32'h66554433);

        // Split SH at offset 3
        issue(1'b0, 3'b001, 32'h07, 32'h0000ABCD);
        ack_access("sh_a", 32'h04, 4'b1000, 32'hCD0000AB, 1'b1, 32'h0);
        ack_access("sh_b", 32'h08, 4'b0001, 32'hCD0000AB, 1'b1, 32'h0);
        expect_resp("sh", 1'b0, 32'h0);

        // SB into lane 1
        issue(1'b0, 3'b000, 32'h05, 32'h12345678);
        ack_access("sb", 32'h04, 4'b0010, 32'h34567812, 1'b1, 32'h0);
        expect_resp("sb", 1'b0, 32'h0);

        // Split LHU at offset 3, zero extension of 0xE2F1
        issue(1'b1, 3'b101, 32'h103, 32'h0);
        ack_access("lhu_a", 32'h100, 4'b0000, 32'h0, 1'b0, 32'hF1000000);
        ack_access("lhu_b", 32'h104, 4'b0000, 32'h0, 1'b0, 32'h000000E2);
        expect_resp("lhu", 1'b0, 32'h0000E2F1);

        // Timeout with MAX_WAIT = 4, then a late ack
        issue(1'b1, 3'b010, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_mem_req_held", 32'(mem_req), 32'd1);
            step();
        end
        chk("to_mem_req_drop", 32'(mem_req), 32'd0);
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_resp_err", 32'(resp_err), 32'd1);
        chk("to_resp_rdata", resp_rdata, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("late_ack_resp_valid", 32'(resp_valid), 32'd0);
        chk("late_ack_ready", 32'(req_ready), 32'd1);
        chk("late_ack_mem_req", 32'(mem_req), 32'd0);
        step();
        chk("late_ack_no_resp", 32'(resp_valid), 32'd0);

        // Illegal codes: no access, response in cycle 1
        issue(1'b1, 3'b011, 32'h0, 32'h0);
        chk("ill_ld_mem_req", 32'(mem_req), 32'd0);
        expect_resp("ill_ld", 1'b1, 32'h0);
        issue(1'b0, 3'b100, 32'h8, 32'h1);
        chk("ill_st_mem_req", 32'(mem_req), 32'd0);
        expect_resp("ill_st", 1'b1, 32'h0);

        // Reset during ACC1 of a split LW
        issue(1'b1, 3'b010, 32'h22, 32'h0);
        ack_access("rst_lw_a", 32'h20, 4'b0000, 32'h0, 1'b0, 32'h44332211);
        chk("rst_acc1_mem_req", 32'(mem_req), 32'd1);
        chk("rst_acc1_mem_addr", mem_addr, 32'h24);
        rst = 1'b1;
        step();
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
            step();
        end

        // Recovery after reset
        issue(1'b1, 3'b010, 32'h30, 32'h0);
        ack_access("post_rst_lw", 32'h30, 4'b0000, 32'h0, 1'b0, 32'hCAFEF00D);
        expect_resp("post_rst_lw", 1'b0, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
